// File: rtl/rx_crc_compare.sv
// Receive-side HMC CRC-32K checker: forwards FLIT words unmodified and flags CRC error / poison on each tail FLIT.
// Latency: fixed 4 cycles from d_in_* to d_out_*, full throughput of one word per cycle.
// Backpressure: none; the input is accepted every cycle it is valid, and the output has no ready.
//
// Ports:
//   clk, res_n            clock, asynchronous active-low reset
//   d_in_valid/hdr/tail   input word qualifier and per-FLIT header/tail flags
//   d_in_data             FPW FLITs, FLIT f at bits [f*128 +: 128]
//   d_out_valid/hdr/tail  input qualifiers delayed by 4 cycles (flags forced to 0 on invalid slots)
//   d_out_data            input data delayed by 4 cycles, unmodified
//   d_out_crc_err         per-FLIT CRC mismatch, only in the tail FLIT position
//   d_out_poison          per-FLIT poison (received CRC == ~computed CRC), only in the tail FLIT position
//   crc_err_cnt           saturating error count; built only when RX_CRC_ERR_CNT_EN is defined, else 0
//
// CRC: polynomial 0x741B8CD7, init 0, no final XOR, no reflection. Bits are fed
// serially from bit 127 down to bit 0 of each FLIT, FLIT 0 of a word first.
// The tail FLIT's CRC field [127:96] is treated as zero for the computation.
//
// Optional feature macro: RX_CRC_ERR_CNT_EN (error counter).

module rx_crc_compare #(
  parameter int LOG_FPW = 2,
  parameter int FPW     = 4,
  parameter int DWIDTH  = 512
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              d_in_valid,
  input  logic [FPW-1:0]    d_in_hdr,
  input  logic [FPW-1:0]    d_in_tail,
  input  logic [DWIDTH-1:0] d_in_data,
  output logic              d_out_valid,
  output logic [FPW-1:0]    d_out_hdr,
  output logic [FPW-1:0]    d_out_tail,
  output logic [DWIDTH-1:0] d_out_data,
  output logic [FPW-1:0]    d_out_crc_err,
  output logic [FPW-1:0]    d_out_poison,
  output logic [15:0]       crc_err_cnt
);

  localparam logic [31:0] POLY = 32'h741B_8CD7;

  // Advance a CRC register over one 128-bit FLIT, MSB first. With c = 0 this
  // is the standalone CRC of the FLIT; with d = 0 it is the positional shift
  // of a partial CRC by one FLIT (multiplication by x^128 mod P).
  function automatic logic [31:0] crc_step128(input logic [31:0] c, input logic [127:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 127; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ POLY;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: per-FLIT CRC from a zero start, tail CRC field masked out.
  // ---------------------------------------------------------------------------
  logic [31:0]       flit_crc [FPW];

  always_comb begin
    logic [127:0] flit;
    for (int f = 0; f < FPW; f++) begin
      flit = d_in_data[f*128 +: 128];
      if (d_in_tail[f]) flit[127:96] = 32'h0;
      flit_crc[f] = crc_step128(32'h0, flit);
    end
  end

  logic              s1_valid;
  logic [FPW-1:0]    s1_hdr;
  logic [FPW-1:0]    s1_tail;
  logic [DWIDTH-1:0] s1_data;
  logic [31:0]       s1_crc [FPW];

  // Header/tail flags are cleared on invalid words so later stages never see
  // a marker from a slot that must not touch the carry or raise a flag.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      s1_valid <= 1'b0;
      s1_hdr   <= '0;
      s1_tail  <= '0;
      s1_data  <= '0;
      for (int f = 0; f < FPW; f++) s1_crc[f] <= 32'h0;
    end else begin
      s1_valid <= d_in_valid;
      s1_hdr   <= d_in_valid ? d_in_hdr  : '0;
      s1_tail  <= d_in_valid ? d_in_tail : '0;
      s1_data  <= d_in_data;
      for (int f = 0; f < FPW; f++) s1_crc[f] <= flit_crc[f];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: every FLIT CRC zero-extended by 0..FPW-1 FLITs, so a segment
  // ending at FLIT f is the XOR of sh[g][f-g] over its FLITs g.
  // ---------------------------------------------------------------------------
  logic [31:0] sh_c [FPW][FPW];

  always_comb begin
    logic [31:0] t;
    for (int g = 0; g < FPW; g++) begin
      t = s1_crc[g];
      sh_c[g][0] = t;
      for (int k = 1; k < FPW; k++) begin
        t = crc_step128(t, 128'h0);
        sh_c[g][k] = t;
      end
    end
  end

  logic              s2_valid;
  logic [FPW-1:0]    s2_hdr;
  logic [FPW-1:0]    s2_tail;
  logic [DWIDTH-1:0] s2_data;
  logic [31:0]       s2_sh [FPW][FPW];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      s2_valid <= 1'b0;
      s2_hdr   <= '0;
      s2_tail  <= '0;
      s2_data  <= '0;
      for (int g = 0; g < FPW; g++)
        for (int k = 0; k < FPW; k++) s2_sh[g][k] <= 32'h0;
    end else begin
      s2_valid <= s1_valid;
      s2_hdr   <= s1_hdr;
      s2_tail  <= s1_tail;
      s2_data  <= s1_data;
      for (int g = 0; g < FPW; g++)
        for (int k = 0; k < FPW; k++) s2_sh[g][k] <= sh_c[g][k];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: packet segmentation within the word plus the cross-word carry.
  // The carry holds the partial CRC of the one packet that may be open across
  // a word boundary; it is shifted by f+1 FLITs when a tail lands at FLIT f.
  // ---------------------------------------------------------------------------
  logic        carry_open;
  logic [31:0] carry_crc;
  logic        carry_open_nxt;
  logic [31:0] carry_crc_nxt;
  logic [31:0] carry_sh [FPW+1];
  logic [31:0] calc_c [FPW];
  logic [FPW-1:0] orphan_c;

  always_comb begin
    logic [31:0] t;
    t = carry_crc;
    carry_sh[0] = t;
    for (int k = 1; k <= FPW; k++) begin
      t = crc_step128(t, 128'h0);
      carry_sh[k] = t;
    end
  end

  always_comb begin
    logic               open;
    logic               from_carry;
    int                 seg_start;
    logic [31:0]        acc;
    logic [LOG_FPW-1:0] k;
    open           = carry_open;
    from_carry     = 1'b1;
    seg_start      = 0;
    acc            = 32'h0;
    k              = '0;
    orphan_c       = '0;
    carry_open_nxt = carry_open;
    carry_crc_nxt  = carry_crc;
    for (int f = 0; f < FPW; f++) begin
      calc_c[f] = 32'h0;
      // A header always starts a fresh segment; any packet still open is
      // silently dropped.
      if (s2_hdr[f]) begin
        open       = 1'b1;
        from_carry = 1'b0;
        seg_start  = f;
      end
      acc = from_carry ? carry_sh[f+1] : 32'h0;
      for (int g = 0; g < FPW; g++) begin
        if (g >= seg_start && g <= f) begin
          k   = LOG_FPW'(f - g);
          acc = acc ^ s2_sh[g][k];
        end
      end
      if (s2_tail[f]) begin
        if (open) calc_c[f] = acc;
        else      orphan_c[f] = 1'b1;
        open       = 1'b0;
        from_carry = 1'b0;
      end
    end
    // acc now covers the open segment through the last FLIT of the word.
    if (s2_valid) begin
      carry_open_nxt = open;
      carry_crc_nxt  = open ? acc : 32'h0;
    end
  end

  logic              s3_valid;
  logic [FPW-1:0]    s3_hdr;
  logic [FPW-1:0]    s3_tail;
  logic [DWIDTH-1:0] s3_data;
  logic [31:0]       s3_calc [FPW];
  logic [FPW-1:0]    s3_orphan;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      carry_open <= 1'b0;
      carry_crc  <= 32'h0;
      s3_valid   <= 1'b0;
      s3_hdr     <= '0;
      s3_tail    <= '0;
      s3_data    <= '0;
      s3_orphan  <= '0;
      for (int f = 0; f < FPW; f++) s3_calc[f] <= 32'h0;
    end else begin
      carry_open <= carry_open_nxt;
      carry_crc  <= carry_crc_nxt;
      s3_valid   <= s2_valid;
      s3_hdr     <= s2_hdr;
      s3_tail    <= s2_tail;
      s3_data    <= s2_data;
      s3_orphan  <= orphan_c;
      for (int f = 0; f < FPW; f++) s3_calc[f] <= calc_c[f];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: compare against the received CRC field and register outputs.
  // ---------------------------------------------------------------------------
  logic [FPW-1:0] err_c;
  logic [FPW-1:0] poison_c;

  always_comb begin
    logic [31:0] rx;
    err_c    = '0;
    poison_c = '0;
    for (int f = 0; f < FPW; f++) begin
      rx = s3_data[f*128+96 +: 32];
      if (s3_tail[f]) begin
        if (s3_orphan[f])              err_c[f]    = 1'b1;
        else if (rx == s3_calc[f])     err_c[f]    = 1'b0;
        else if (rx == ~s3_calc[f])    poison_c[f] = 1'b1;
        else                           err_c[f]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      d_out_valid   <= 1'b0;
      d_out_hdr     <= '0;
      d_out_tail    <= '0;
      d_out_data    <= '0;
      d_out_crc_err <= '0;
      d_out_poison  <= '0;
    end else begin
      d_out_valid   <= s3_valid;
      d_out_hdr     <= s3_hdr;
      d_out_tail    <= s3_tail;
      d_out_data    <= s3_data;
      d_out_crc_err <= err_c;
      d_out_poison  <= poison_c;
    end
  end

`ifdef RX_CRC_ERR_CNT_EN
  // Counts the error bits visible on d_out_crc_err; the extra sum bit detects
  // overflow so the count sticks at 0xFFFF.
  logic [16:0] cnt_sum;
  logic [15:0] cnt_q;

  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    for (int f = 0; f < FPW; f++) cnt_sum = cnt_sum + 17'(d_out_crc_err[f]);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) cnt_q <= 16'h0;
    else        cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign crc_err_cnt = cnt_q;
`else
  assign crc_err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_rx_crc_compare.sv
module tb_rx_crc_compare;
  localparam int LOG_FPW = 2;
  localparam int FPW     = 4;
  localparam int DWIDTH  = 512;
  localparam logic [31:0] POLY = 32'h741B_8CD7;
`ifdef RX_CRC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              res_n = 1'b0;
  logic              d_in_valid;
  logic [FPW-1:0]    d_in_hdr, d_in_tail;
  logic [DWIDTH-1:0] d_in_data;
  logic              d_out_valid;
  logic [FPW-1:0]    d_out_hdr, d_out_tail, d_out_crc_err, d_out_poison;
  logic [DWIDTH-1:0] d_out_data;
  logic [15:0]       crc_err_cnt;

  int errors = 0;
  int checks = 0;

  rx_crc_compare #(.LOG_FPW(LOG_FPW), .FPW(FPW), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .res_n(res_n),
    .d_in_valid(d_in_valid), .d_in_hdr(d_in_hdr), .d_in_tail(d_in_tail), .d_in_data(d_in_data),
    .d_out_valid(d_out_valid), .d_out_hdr(d_out_hdr), .d_out_tail(d_out_tail), .d_out_data(d_out_data),
    .d_out_crc_err(d_out_crc_err), .d_out_poison(d_out_poison), .crc_err_cnt(crc_err_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus words and the output slots captured 4 cycles later.
  logic              w_vld  [16];
  logic [FPW-1:0]    w_hdr  [16];
  logic [FPW-1:0]    w_tail [16];
  logic [DWIDTH-1:0] w_dat  [16];
  logic              c_vld  [16];
  logic [FPW-1:0]    c_hdr  [16];
  logic [FPW-1:0]    c_tail [16];
  logic [FPW-1:0]    c_err  [16];
  logic [FPW-1:0]    c_poi  [16];
  logic [DWIDTH-1:0] c_dat  [16];
  logic [127:0]      pk     [16];

  // Bit-serial reference CRC over pk[0..n-1], last FLIT's CRC field as zero.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0]  c;
    logic [127:0] f;
    logic         fb;
    c = 32'h0;
    for (int j = 0; j < n; j++) begin
      f = pk[j];
      if (j == n - 1) f[127:96] = 32'h0;
      for (int i = 127; i >= 0; i--) begin
        fb = c[31] ^ f[i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  function automatic logic [127:0] mk_flit(input int s);
    logic [31:0] a;
    a = 32'(s);
    return {a * 32'h9E37_79B9, a ^ 32'hA5A5_5A5A, ~(a * 32'h0100_0193), a + 32'h1357_9BDF};
  endfunction

  // mode 0: correct CRC, 1: inverted (poison), 2: corrupted (error)
  task automatic seal(input int n, input int mode);
    logic [31:0] c;
    c = ref_crc(n);
    pk[n-1][127:96] = (mode == 0) ? c : (mode == 1) ? ~c : (c ^ 32'h0000_0001);
  endtask

  task automatic put(input int w, input int pos, input logic [127:0] fl);
    w_dat[w][pos*128 +: 128] = fl;
  endtask

  task automatic clear_words();
    for (int i = 0; i < 16; i++) begin
      w_vld[i] = 1'b0; w_hdr[i] = '0; w_tail[i] = '0; w_dat[i] = '0;
    end
  endtask

  task automatic drive_idle();
    d_in_valid = 1'b0; d_in_hdr = '0; d_in_tail = '0; d_in_data = '0;
  endtask

  // Drives words 0..n-1 back to back; slot i of c_* holds the output seen 4 cycles after word i.
  task automatic run_words(input int n);
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) begin
        d_in_valid = w_vld[i]; d_in_hdr = w_hdr[i]; d_in_tail = w_tail[i]; d_in_data = w_dat[i];
      end else drive_idle();
      @(posedge clk); #1;
      if (i >= 3) begin
        c_vld[i-3] = d_out_valid; c_hdr[i-3] = d_out_hdr; c_tail[i-3] = d_out_tail;
        c_err[i-3] = d_out_crc_err; c_poi[i-3] = d_out_poison; c_dat[i-3] = d_out_data;
      end
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    d_in_valid = 1'b1; d_in_hdr = '0; d_in_tail = '0; d_in_data = {16{32'hDEAD_BEEF}};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({d_out_valid, d_out_hdr, d_out_tail, d_out_crc_err, d_out_poison} !== '0 ||
          d_out_data !== '0 || crc_err_cnt !== 16'h0) begin
        errors++; $display("FAIL reset_outputs: got valid=%b err=%b cnt=%h want all zero", d_out_valid, d_out_crc_err, crc_err_cnt);
      end
    end
    res_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (d_out_valid !== (c == 4)) begin
        errors++; $display("FAIL reset_release_valid cycle %0d: got %b want %b", c, d_out_valid, (c == 4));
      end
    end
    checks++;
    if (d_out_data !== {16{32'hDEAD_BEEF}}) begin
      errors++; $display("FAIL reset_release_data: got %h want %h", d_out_data[31:0], 32'hDEAD_BEEF);
    end
    drive_idle();
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic single_flit(input int flip);
    clear_words();
    pk[0] = mk_flit(1);
    seal(1, 0);
    if (flip != 0) pk[0][5] = ~pk[0][5];
    w_vld[1] = 1'b1; w_hdr[1] = 4'b0001; w_tail[1] = 4'b0001;
    put(1, 0, pk[0]); put(1, 1, mk_flit(2)); put(1, 2, mk_flit(3)); put(1, 3, mk_flit(4));
    run_words(2);
  endtask

  task automatic test_single_clean();
    single_flit(0);
    checks++; if (c_vld[0] !== 1'b0) begin errors++; $display("FAIL single_clean early_valid: got %b want 0", c_vld[0]); end
    checks++; if (c_vld[1] !== 1'b1) begin errors++; $display("FAIL single_clean valid: got %b want 1", c_vld[1]); end
    checks++; if (c_dat[1] !== w_dat[1]) begin errors++; $display("FAIL single_clean data: got %h want %h", c_dat[1][127:0], w_dat[1][127:0]); end
    checks++; if ({c_hdr[1], c_tail[1]} !== 8'b0001_0001) begin errors++; $display("FAIL single_clean hdr_tail: got %b want 00010001", {c_hdr[1], c_tail[1]}); end
    checks++; if ({c_err[1], c_poi[1]} !== 8'h00) begin errors++; $display("FAIL single_clean flags: got err=%b poison=%b want 0000/0000", c_err[1], c_poi[1]); end
  endtask

  task automatic test_single_err();
    logic [15:0] exp_cnt;
    single_flit(1);
    exp_cnt = CNT_EN ? 16'd1 : 16'd0;
    checks++; if (c_err[1] !== 4'b0001) begin errors++; $display("FAIL single_err err: got %b want 0001", c_err[1]); end
    checks++; if (c_poi[1] !== 4'b0000) begin errors++; $display("FAIL single_err poison: got %b want 0000", c_poi[1]); end
    checks++; if (crc_err_cnt !== exp_cnt) begin errors++; $display("FAIL single_err count: got %0d want %0d", crc_err_cnt, exp_cnt); end
  endtask

  task automatic test_multiword_gap();
    clear_words();
    for (int j = 0; j < 9; j++) pk[j] = mk_flit(10 + j);
    seal(9, 0);
    w_vld[1] = 1'b1; w_hdr[1] = 4'b0100;
    put(1, 0, mk_flit(99)); put(1, 1, mk_flit(98)); put(1, 2, pk[0]); put(1, 3, pk[1]);
    w_vld[2] = 1'b1;
    for (int f = 0; f < 4; f++) put(2, f, pk[2+f]);
    // Invalid word carrying junk markers; it must leave the carry untouched.
    w_vld[3] = 1'b0; w_hdr[3] = 4'b1111; w_tail[3] = 4'b1111; w_dat[3] = {16{32'h0BAD_F00D}};
    w_vld[4] = 1'b1; w_tail[4] = 4'b0100;
    put(4, 0, pk[6]); put(4, 1, pk[7]); put(4, 2, pk[8]); put(4, 3, mk_flit(97));
    run_words(5);
    checks++; if (c_vld[2] !== 1'b1) begin errors++; $display("FAIL gap word1_valid: got %b want 1", c_vld[2]); end
    checks++; if (c_vld[3] !== 1'b0) begin errors++; $display("FAIL gap slot_valid: got %b want 0", c_vld[3]); end
    checks++; if ({c_err[3], c_poi[3]} !== 8'h00) begin errors++; $display("FAIL gap slot_flags: got err=%b poison=%b want 0", c_err[3], c_poi[3]); end
    checks++; if (c_vld[4] !== 1'b1 || c_tail[4] !== 4'b0100) begin errors++; $display("FAIL gap tail_word: got valid=%b tail=%b want 1/0100", c_vld[4], c_tail[4]); end
    checks++; if ({c_err[4], c_poi[4]} !== 8'h00) begin errors++; $display("FAIL gap nine_flit_flags: got err=%b poison=%b want 0000/0000", c_err[4], c_poi[4]); end
    checks++; if (c_dat[4] !== w_dat[4]) begin errors++; $display("FAIL gap data: got %h want %h", c_dat[4][127:0], w_dat[4][127:0]); end
  endtask

  task automatic test_two_packets_poison();
    clear_words();
    pk[0] = mk_flit(20); pk[1] = mk_flit(21); seal(2, 0);
    put(1, 0, pk[0]); put(1, 1, pk[1]);
    pk[0] = mk_flit(22); pk[1] = mk_flit(23); seal(2, 1);
    put(1, 2, pk[0]); put(1, 3, pk[1]);
    w_vld[1] = 1'b1; w_hdr[1] = 4'b0101; w_tail[1] = 4'b1010;
    run_words(2);
    checks++; if (c_poi[1] !== 4'b1000) begin errors++; $display("FAIL two_pkt poison: got %b want 1000", c_poi[1]); end
    checks++; if (c_err[1] !== 4'b0000) begin errors++; $display("FAIL two_pkt err: got %b want 0000", c_err[1]); end
  endtask

  task automatic test_reset_midpacket();
    logic [15:0] exp_cnt;
    clear_words();
    for (int j = 0; j < 5; j++) pk[j] = mk_flit(40 + j);
    seal(5, 0);
    d_in_valid = 1'b1; d_in_hdr = 4'b0001; d_in_tail = 4'b0000;
    d_in_data = {pk[3], pk[2], pk[1], pk[0]};
    @(posedge clk); #1;
    res_n = 1'b0;
    drive_idle();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (d_out_valid !== 1'b0 || d_out_data !== '0 || d_out_crc_err !== '0 || crc_err_cnt !== 16'h0) begin
        errors++; $display("FAIL midreset_outputs: got valid=%b err=%b cnt=%h want zero", d_out_valid, d_out_crc_err, crc_err_cnt);
      end
    end
    res_n = 1'b1;
    // Tail holding the correct CRC of the interrupted packet: with the carry
    // cleared by reset it has no open packet and must be an error.
    w_vld[1] = 1'b1; w_tail[1] = 4'b0001; put(1, 0, pk[4]);
    pk[0] = mk_flit(50); seal(1, 0);
    w_vld[2] = 1'b1; w_hdr[2] = 4'b0010; w_tail[2] = 4'b0010; put(2, 1, pk[0]);
    run_words(3);
    exp_cnt = CNT_EN ? 16'd1 : 16'd0;
    checks++; if (c_vld[0] !== 1'b0) begin errors++; $display("FAIL midreset idle_slot: got %b want 0", c_vld[0]); end
    checks++; if ({c_err[1], c_poi[1]} !== 8'b0001_0000) begin errors++; $display("FAIL midreset stale_tail: got err=%b poison=%b want 0001/0000", c_err[1], c_poi[1]); end
    checks++; if ({c_err[2], c_poi[2]} !== 8'h00 || c_tail[2] !== 4'b0010) begin errors++; $display("FAIL midreset clean_pkt: got err=%b poison=%b tail=%b want 0000/0000/0010", c_err[2], c_poi[2], c_tail[2]); end
    checks++; if (crc_err_cnt !== exp_cnt) begin errors++; $display("FAIL midreset count: got %0d want %0d", crc_err_cnt, exp_cnt); end
  endtask

  task automatic test_hdr_restart();
    clear_words();
    w_vld[1] = 1'b1; w_hdr[1] = 4'b0001;
    for (int f = 0; f < 4; f++) put(1, f, mk_flit(60 + f));
    pk[0] = mk_flit(70); pk[1] = mk_flit(71); seal(2, 0);
    w_vld[2] = 1'b1; w_hdr[2] = 4'b0010; w_tail[2] = 4'b0100;
    put(2, 0, mk_flit(64)); put(2, 1, pk[0]); put(2, 2, pk[1]); put(2, 3, mk_flit(65));
    run_words(3);
    checks++; if ({c_err[1], c_poi[1]} !== 8'h00) begin errors++; $display("FAIL restart open_word: got err=%b poison=%b want 0", c_err[1], c_poi[1]); end
    checks++; if ({c_err[2], c_poi[2]} !== 8'h00) begin errors++; $display("FAIL restart new_pkt: got err=%b poison=%b want 0000/0000", c_err[2], c_poi[2]); end
  endtask

  task automatic test_back_to_back();
    int mode [4][4];
    logic [FPW-1:0] exp_err [6];
    logic [FPW-1:0] exp_poi [6];
    logic [15:0] exp_cnt;
    clear_words();
    for (int w = 0; w < 4; w++) for (int f = 0; f < 4; f++) mode[w][f] = 0;
    mode[2][1] = 2; mode[2][3] = 2; mode[3][2] = 1;
    for (int w = 1; w <= 3; w++) begin
      w_vld[w] = 1'b1; w_hdr[w] = 4'b1111; w_tail[w] = 4'b1111;
      for (int f = 0; f < 4; f++) begin
        pk[0] = mk_flit(80 + 4*w + f); seal(1, mode[w][f]); put(w, f, pk[0]);
      end
    end
    pk[0] = mk_flit(110); seal(1, 0); put(4, 0, pk[0]);
    put(4, 1, mk_flit(111)); put(4, 2, mk_flit(112));
    pk[0] = mk_flit(113); pk[1] = mk_flit(114); seal(2, 0); put(4, 3, pk[0]); put(5, 0, pk[1]);
    put(5, 1, mk_flit(117));
    pk[0] = mk_flit(115); pk[1] = mk_flit(116); seal(2, 0); put(5, 2, pk[0]); put(5, 3, pk[1]);
    w_vld[4] = 1'b1; w_hdr[4] = 4'b1001; w_tail[4] = 4'b0001;
    w_vld[5] = 1'b1; w_hdr[5] = 4'b0100; w_tail[5] = 4'b1001;
    exp_err = '{4'b0000, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000};
    exp_poi = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    run_words(6);
    for (int w = 1; w <= 5; w++) begin
      checks++;
      if (c_vld[w] !== 1'b1 || c_err[w] !== exp_err[w] || c_poi[w] !== exp_poi[w]) begin
        errors++; $display("FAIL b2b word%0d: got valid=%b err=%b poison=%b want 1/%b/%b", w, c_vld[w], c_err[w], c_poi[w], exp_err[w], exp_poi[w]);
      end
    end
    exp_cnt = CNT_EN ? 16'd3 : 16'd0;
    checks++; if (crc_err_cnt !== exp_cnt) begin errors++; $display("FAIL b2b count: got %0d want %0d", crc_err_cnt, exp_cnt); end
  endtask

`ifdef RX_CRC_ERR_CNT_EN
  // Zero payload gives computed CRC 0; received CRC 1 is neither equal nor inverse.
  task automatic stream_errors(input int n);
    d_in_valid = 1'b1; d_in_hdr = 4'b1111; d_in_tail = 4'b1111;
    d_in_data = '0;
    for (int f = 0; f < 4; f++) d_in_data[f*128+96 +: 32] = 32'h1;
    repeat (n) begin @(posedge clk); #1; end
    drive_idle();
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic test_counter_saturation();
    stream_errors(100);
    checks++; if (crc_err_cnt !== 16'd403) begin errors++; $display("FAIL sat partial_count: got %0d want 403", crc_err_cnt); end
    stream_errors(16384);
    checks++; if (crc_err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat count: got %h want ffff", crc_err_cnt); end
    stream_errors(1);
    checks++; if (crc_err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat hold: got %h want ffff", crc_err_cnt); end
  endtask
`endif

  initial begin
    drive_idle();
    res_n = 1'b0;
    test_reset();
    test_single_clean();
    test_single_err();
    test_multiword_gap();
    test_two_packets_poison();
    test_reset_midpacket();
    test_hdr_restart();
    test_back_to_back();
`ifdef RX_CRC_ERR_CNT_EN
    test_counter_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
